// File: rtl/bytebeat_pkg.sv
// -----------------------------------------------------------------------------
// bytebeat_pkg
// Shared constants and types for the bytebeat PWM output bank.
//   SAMPLE_W_DEF   default sample width (also sets the PWM period, 2^SAMPLE_W)
//   DIV_W_DEF      default width of the sample-period divider
//   CHANNELS_DEF   default channel count (power of two, 1..16)
//   CHAN_SHIFT_DEF log2 of the default channel count, the averaging shift
//   sample_t       one unsigned sample at the default width
// Optional feature macro used by the bank: BYTEBEAT_PWM_MIX_EN
// -----------------------------------------------------------------------------
package bytebeat_pkg;

   localparam int SAMPLE_W_DEF   = 8;
   localparam int DIV_W_DEF      = 12;
   localparam int CHANNELS_DEF   = 8;
   localparam int CHAN_SHIFT_DEF = $clog2(CHANNELS_DEF);

   typedef logic [SAMPLE_W_DEF-1:0] sample_t;

   // Averaging shift for an arbitrary power-of-two channel count; a single
   // channel needs no shift at all.
   function automatic int chanShift(input int channels);
      return (channels <= 1) ? 0 : $clog2(channels);
   endfunction

endpackage

// File: rtl/pwm_duty_channel.sv
// -----------------------------------------------------------------------------
// pwm_duty_channel
// One glitch-free PWM lane. The requested level is only copied into the duty
// shadow register on the PWM wrap, so a pin never sees a duty change in the
// middle of a period. The pin itself is a register.
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   pcnt_i   shared free-running PWM counter from the parent
//   wrap_i   high while pcnt_i sits at its maximum value
//   level_i  requested duty (high cycles per period)
//   pwm_o    registered PWM output
// -----------------------------------------------------------------------------
import bytebeat_pkg::*;

module pwm_duty_channel #(
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] pcnt_i,
   input  logic                wrap_i,
   input  logic [SAMPLE_W-1:0] level_i,
   output logic                pwm_o
);

   logic [SAMPLE_W-1:0] duty_q;
   logic [SAMPLE_W-1:0] duty_d;
   logic                pwm_q;
   logic                pwm_d;

   // Next duty is the new level only at the wrap; the compare uses the duty
   // currently in force, so a level of 0 never drives high and the maximum
   // level drives high for all but the last count of the period.
   always_comb begin
      duty_d = duty_q;
      if (wrap_i) begin
         duty_d = level_i;
      end
      pwm_d = (pcnt_i < duty_q);
   end

   // Duty shadow and output pin registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/bytebeat_pwm_bank.sv
// -----------------------------------------------------------------------------
// bytebeat_pwm_bank
// Multi-channel audio back-end: a programmable sample-rate tick, one staging
// slot per channel fed over valid/ready, sticky underrun flags and one PWM pin
// per channel. Optional mixed mono PWM output, enabled by defining
// BYTEBEAT_PWM_MIX_EN; without it mix_pwm is tied low and no mix logic exists.
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   div           sample period minus one, in clk cycles
//   tick          one-cycle sample strobe (cnt >= div)
//   s_data        sample for channel i at [i*SAMPLE_W +: SAMPLE_W], unsigned
//   s_vld         per-channel sample valid
//   s_rdy         per-channel ready, high while that channel's stage is empty
//   clr_underrun  synchronous clear of all underrun flags
//   underrun      sticky per-channel underrun flags
//   pwm           per-channel PWM outputs
//   mix_pwm       PWM of the channel average (0 when mix is compiled out)
// -----------------------------------------------------------------------------
import bytebeat_pkg::*;

module bytebeat_pwm_bank #(
   parameter int CHANNELS = CHANNELS_DEF,
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int DIV_W    = DIV_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DIV_W-1:0]             div,
   output logic                         tick,
   input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
   input  logic [CHANNELS-1:0]          s_vld,
   output logic [CHANNELS-1:0]          s_rdy,
   input  logic                         clr_underrun,
   output logic [CHANNELS-1:0]          underrun,
   output logic [CHANNELS-1:0]          pwm,
   output logic                         mix_pwm
);

   logic [DIV_W-1:0]                   cnt_q;
   logic [DIV_W-1:0]                   cnt_d;
   logic [SAMPLE_W-1:0]                pcnt_q;
   logic [SAMPLE_W-1:0]                pcnt_d;
   logic                               wrap;
   logic [CHANNELS-1:0][SAMPLE_W-1:0]  stage_q;
   logic [CHANNELS-1:0][SAMPLE_W-1:0]  stage_d;
   logic [CHANNELS-1:0][SAMPLE_W-1:0]  active_q;
   logic [CHANNELS-1:0][SAMPLE_W-1:0]  active_d;
   logic [CHANNELS-1:0]                full_q;
   logic [CHANNELS-1:0]                full_d;
   logic [CHANNELS-1:0]                underrun_q;
   logic [CHANNELS-1:0]                underrun_d;
   logic [CHANNELS-1:0]                accept;

   // Sample-rate counter. The tick is a compare rather than an equality, so
   // lowering div below the running count ticks at once instead of letting
   // the counter run round through its maximum value.
   always_comb begin
      tick  = (cnt_q >= div);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Shared PWM counter; it simply wraps, and the maximum value is the point
   // where every lane may take up a new duty.
   always_comb begin
      pcnt_d = pcnt_q + 1'b1;
      wrap   = &pcnt_q;
   end

   // Ready depends only on registered state, never on s_vld.
   assign s_rdy  = ~full_q;
   assign accept = s_vld & s_rdy;

   // Staging, sample promotion and underrun tracking. A capture needs an
   // empty stage and a promotion needs a full one, so the two never collide
   // on the same channel: a capture on the tick cycle sees an empty stage,
   // flags an underrun and waits in the stage for the following tick. A new
   // underrun is applied after the clear so that setting beats clearing.
   always_comb begin
      stage_d    = stage_q;
      full_d     = full_q;
      active_d   = active_q;
      underrun_d = clr_underrun ? '0 : underrun_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (tick) begin
            if (full_q[i]) begin
               active_d[i] = stage_q[i];
               full_d[i]   = 1'b0;
            end else begin
               underrun_d[i] = 1'b1;
            end
         end
         if (accept[i]) begin
            stage_d[i] = s_data[i*SAMPLE_W +: SAMPLE_W];
            full_d[i]  = 1'b1;
         end
      end
   end

   // All bank state; reset throws away staged samples and sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         pcnt_q     <= '0;
         stage_q    <= '0;
         full_q     <= '0;
         active_q   <= '0;
         underrun_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         pcnt_q     <= pcnt_d;
         stage_q    <= stage_d;
         full_q     <= full_d;
         active_q   <= active_d;
         underrun_q <= underrun_d;
      end
   end

   assign underrun = underrun_q;

   // One PWM lane per channel, all sharing the counter and wrap strobe.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      pwm_duty_channel #(
         .SAMPLE_W (SAMPLE_W)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .pcnt_i  (pcnt_q),
         .wrap_i  (wrap),
         .level_i (active_q[g]),
         .pwm_o   (pwm[g])
      );
   end

`ifdef BYTEBEAT_PWM_MIX_EN
   localparam int SHIFT = (CHANNELS == CHANNELS_DEF) ? CHAN_SHIFT_DEF : chanShift(CHANNELS);
   localparam int SUM_W = SAMPLE_W + SHIFT;

   logic [SUM_W-1:0]    mixSum_q;
   logic [SUM_W-1:0]    mixSum_d;
   logic [SAMPLE_W-1:0] mixLevel;

   // Sum of the active samples, wide enough that it cannot overflow; the
   // shift back down turns it into the average.
   always_comb begin
      mixSum_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         mixSum_d = mixSum_d + SUM_W'(active_q[i]);
      end
   end

   // The sum is registered to keep the adder tree off the duty load path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mixSum_q <= '0;
      end else begin
         mixSum_q <= mixSum_d;
      end
   end

   assign mixLevel = SAMPLE_W'(mixSum_q >> SHIFT);

   pwm_duty_channel #(
      .SAMPLE_W (SAMPLE_W)
   ) u_mix (
      .clk     (clk),
      .rst_n   (rst_n),
      .pcnt_i  (pcnt_q),
      .wrap_i  (wrap),
      .level_i (mixLevel),
      .pwm_o   (mix_pwm)
   );
`else
   assign mix_pwm = 1'b0;
`endif

endmodule

// File: tb/tb_bytebeat_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_bytebeat_pwm_bank
// Directed bench for bytebeat_pwm_bank with CHANNELS=4, SAMPLE_W=8, DIV_W=12.
// Cycle numbers below are edges since reset release, so with div=511 the tick
// is high in cycles 511, 1023, 1535, ... and active samples change at the
// following edge. Duty follows at the next pcnt wrap, i.e. at edges that are
// multiples of 256. Expected mix values depend on BYTEBEAT_PWM_MIX_EN.
// -----------------------------------------------------------------------------
module tb_bytebeat_pwm_bank;

   localparam int CH = 4;
   localparam int SW = 8;
   localparam int DW = 12;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [DW-1:0]    div;
   logic             tick;
   logic [CH*SW-1:0] s_data;
   logic [CH-1:0]    s_vld;
   logic [CH-1:0]    s_rdy;
   logic             clr_underrun;
   logic [CH-1:0]    underrun;
   logic [CH-1:0]    pwm;
   logic             mix_pwm;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int tickCount = 0;
   int pwmSeen = 0;
   int pwm1Ever = 0;
   int c0, c1, c2, c3, cm;
   int tcBase;
   int expMixA, expMixB, expMixC;

   bytebeat_pwm_bank #(
      .CHANNELS (CH),
      .SAMPLE_W (SW),
      .DIV_W    (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .div          (div),
      .tick         (tick),
      .s_data       (s_data),
      .s_vld        (s_vld),
      .s_rdy        (s_rdy),
      .clr_underrun (clr_underrun),
      .underrun     (underrun),
      .pwm          (pwm),
      .mix_pwm      (mix_pwm)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports and counts a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and look at the outputs 1 ns later.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      cyc++;
      if (tick) tickCount++;
      if (pwm != '0 || mix_pwm) pwmSeen++;
      if (pwm[1]) pwm1Ever++;
   endtask

   task automatic stepTo(input int n);
      while (cyc < n) stepCycle();
   endtask

   // Drive one channel's valid and data lane.
   task automatic applyStimulus(input int ch, input logic vld, input logic [SW-1:0] data);
      s_vld[ch]             = vld;
      s_data[ch*SW +: SW]   = data;
   endtask

   // Count high cycles on every pin across one full 256-cycle PWM period.
   task automatic countWindow(output int o0, output int o1, output int o2, output int o3, output int om);
      o0 = 0; o1 = 0; o2 = 0; o3 = 0; om = 0;
      repeat (256) begin
         stepCycle();
         o0 += int'(pwm[0]);
         o1 += int'(pwm[1]);
         o2 += int'(pwm[2]);
         o3 += int'(pwm[3]);
         om += int'(mix_pwm);
      end
   endtask

   // The whole directed sequence.
   initial begin
`ifdef BYTEBEAT_PWM_MIX_EN
      expMixA = 104;  // (0x80+0x00+0xFF+0x22)>>2
      expMixB = 88;   // (0x40+0x00+0xFF+0x22)>>2
      expMixC = 84;   // (0x40+0x00+0xFF+0x11)>>2
`else
      expMixA = 0;
      expMixB = 0;
      expMixC = 0;
`endif
      rst_n        = 1'b0;
      div          = 12'd511;
      s_data       = '0;
      s_vld        = '0;
      clr_underrun = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;

      // Reset state.
      checkOutput("rst_tick", 32'(tick), 32'd0);
      checkOutput("rst_rdy", 32'(s_rdy), 32'hF);
      checkOutput("rst_underrun", 32'(underrun), 32'd0);
      checkOutput("rst_pwm", 32'(pwm), 32'd0);
      checkOutput("rst_mix", 32'(mix_pwm), 32'd0);

      // Idle: a single tick at cycle 511, every channel underruns.
      stepTo(510);
      checkOutput("idle_no_early_tick", 32'(tickCount), 32'd0);
      stepCycle();
      checkOutput("idle_tick_511", 32'(tick), 32'd1);
      stepCycle();
      checkOutput("idle_tick_512", 32'(tick), 32'd0);
      checkOutput("idle_underrun", 32'(underrun), 32'hF);
      checkOutput("idle_rdy", 32'(s_rdy), 32'hF);
      checkOutput("idle_pwm_quiet", 32'(pwmSeen), 32'd0);

      // Clear the flags.
      clr_underrun = 1'b1;
      stepCycle();
      clr_underrun = 1'b0;
      checkOutput("clr_underrun", 32'(underrun), 32'd0);

      // Handshake on ch0; ch1=0x00, ch2=0xFF, ch3=0x22 follow one cycle later.
      stepTo(522);
      applyStimulus(0, 1'b1, 8'h80);
      checkOutput("hs_rdy_before", 32'(s_rdy[0]), 32'd1);
      stepCycle();
      checkOutput("hs_rdy_fall", 32'(s_rdy[0]), 32'd0);
      applyStimulus(0, 1'b1, 8'h40);
      applyStimulus(1, 1'b1, 8'h00);
      applyStimulus(2, 1'b1, 8'hFF);
      applyStimulus(3, 1'b1, 8'h22);
      stepCycle();
      checkOutput("hs_all_full", 32'(s_rdy), 32'd0);
      stepTo(1023);
      checkOutput("hs_tick_1023", 32'(tick), 32'd1);
      checkOutput("hs_held_until_tick", 32'(s_rdy), 32'd0);
      applyStimulus(3, 1'b0, 8'h22);
      stepCycle();
      checkOutput("hs_rdy_after_tick", 32'(s_rdy), 32'hF);
      checkOutput("hs_no_underrun", 32'(underrun), 32'd0);
      stepCycle();
      checkOutput("hs_0x40_staged", 32'(s_rdy), 32'h8);
      applyStimulus(0, 1'b0, 8'h40);

      // Duty 0x80/0x00/0xFF/0x22 takes effect after the wrap at edge 1280.
      stepTo(1280);
      countWindow(c0, c1, c2, c3, cm);
      checkOutput("win1_pwm0", 32'(c0), 32'd128);
      checkOutput("win1_pwm1", 32'(c1), 32'd0);
      checkOutput("win1_pwm2", 32'(c2), 32'd255);
      checkOutput("win1_pwm3", 32'(c3), 32'd34);
      checkOutput("win1_mix", 32'(cm), 32'(expMixA));
      checkOutput("win1_underrun3", 32'(underrun), 32'h8);

      clr_underrun = 1'b1;
      stepCycle();
      clr_underrun = 1'b0;
      checkOutput("clr_underrun2", 32'(underrun), 32'd0);

      // ch3 offers 0x11 exactly on the tick cycle.
      stepTo(2047);
      checkOutput("sim_tick_2047", 32'(tick), 32'd1);
      applyStimulus(3, 1'b1, 8'h11);
      stepCycle();
      applyStimulus(3, 1'b0, 8'h11);
      checkOutput("sim_underrun", 32'(underrun), 32'h9);
      checkOutput("sim_staged", 32'(s_rdy), 32'h7);

      // Next period: ch0 now 0x40, ch3 still repeating 0x22.
      stepTo(2304);
      countWindow(c0, c1, c2, c3, cm);
      checkOutput("win2_pwm0", 32'(c0), 32'd64);
      checkOutput("win2_pwm2", 32'(c2), 32'd255);
      checkOutput("win2_pwm3_unchanged", 32'(c3), 32'd34);
      checkOutput("win2_mix", 32'(cm), 32'(expMixB));

      // Restage ch3 so only ch0 underruns at the 3071 tick, while clearing.
      stepTo(2600);
      applyStimulus(3, 1'b1, 8'h11);
      stepCycle();
      applyStimulus(3, 1'b0, 8'h11);
      checkOutput("restage_ch3", 32'(s_rdy[3]), 32'd0);
      stepTo(3071);
      checkOutput("setwins_tick", 32'(tick), 32'd1);
      clr_underrun = 1'b1;
      stepCycle();
      clr_underrun = 1'b0;
      checkOutput("set_beats_clear", 32'(underrun), 32'h1);

      // ch3 now plays 0x11 from the tick at 2559.
      countWindow(c0, c1, c2, c3, cm);
      checkOutput("win3_pwm0", 32'(c0), 32'd64);
      checkOutput("win3_pwm3", 32'(c3), 32'd17);
      checkOutput("win3_mix", 32'(cm), 32'(expMixC));
      checkOutput("pwm1_never_high", 32'(pwm1Ever), 32'd0);

      // div lowered under the running count (cnt=300 at cycle 3372).
      stepTo(3372);
      div = 12'd100;
      #1;
      checkOutput("div_low_tick_now", 32'(tick), 32'd1);
      stepCycle();
      checkOutput("div_after_restart", 32'(tick), 32'd0);
      tcBase = tickCount;
      stepTo(3472);
      checkOutput("div_no_tick_in_period", 32'(tickCount - tcBase), 32'd0);
      stepCycle();
      checkOutput("div_period_101", 32'(tick), 32'd1);
      div = 12'd0;
      tcBase = tickCount;
      repeat (5) stepCycle();
      checkOutput("div0_constant_tick", 32'(tickCount - tcBase), 32'd5);

      // Reset in mid-operation with a sample staged on ch0.
      div = 12'd511;
      s_vld = '0;
      applyStimulus(0, 1'b1, 8'h55);
      stepCycle();
      applyStimulus(0, 1'b0, 8'h55);
      checkOutput("midrst_staged", 32'(s_rdy[0]), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rdy", 32'(s_rdy), 32'hF);
      checkOutput("midrst_underrun", 32'(underrun), 32'd0);
      checkOutput("midrst_pwm", 32'(pwm), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      tickCount = 0;
      pwmSeen = 0;
      stepTo(20);
      checkOutput("post_rst_quiet", 32'(pwmSeen + tickCount), 32'd0);
      checkOutput("post_rst_rdy", 32'(s_rdy), 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bytebeat_pwm_bank.md
# bytebeat_pwm_bank

Parametrised multi-channel audio back-end that sits between the bytebeat generators and the output pins. It generates a programmable sample-rate tick and accepts one sample per channel per tick over a valid/ready handshake. Each channel has a one-slot staging buffer with sticky underrun detection, and drives a glitch-free PWM pin whose duty changes only at a PWM period boundary. It replaces the fixed divide-by-512 plus per-channel PWM arrangement and adds an optional mixed mono output.

## Interface
- CHANNELS, 8: channel count; power of two, 1..16
- SAMPLE_W, 8: sample width; also sets the PWM period to 2^SAMPLE_W clocks
- DIV_W, 12: width of the sample-period divider
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- div  in  DIV_W  sample period minus one, in clk cycles
- tick  out  1  one-cycle sample strobe; generators advance t on it
- s_data  in  CHANNELS*SAMPLE_W  sample for channel i at [i*SAMPLE_W +: SAMPLE_W], unsigned
- s_vld  in  CHANNELS  per-channel sample valid
- s_rdy  out  CHANNELS  per-channel ready, equal to !stage_full[i]
- clr_underrun  in  1  synchronous clear of all underrun flags
- underrun  out  CHANNELS  sticky per-channel underrun flags
- pwm  out  CHANNELS  per-channel PWM output
- mix_pwm  out  1  PWM of the channel average; constant 0 when the mix feature is compiled out

## Operation
- Sample counter `cnt` (DIV_W bits) increments every cycle. `tick` = (cnt >= div), decoded combinationally from `cnt`. When `tick` is high, `cnt` goes to 0 on the next edge.
  - If `div` is lowered below the current `cnt`, the next cycle ticks. No wrap-around through the maximum value.
  - div=0 ticks every cycle.
- Staging, per channel:
  - On s_vld[i] && s_rdy[i], capture s_data into stage[i] and set stage_full[i].
  - Data offered while the stage is full is held off by the sender (s_rdy low); it is never dropped.
- On tick, per channel:
  - If stage_full: active[i] <= stage[i] and clear stage_full.
  - Else: active[i] holds its value (the last sample repeats) and underrun[i] is set.
  - If the tick and a capture happen in the same cycle, the empty stage is evaluated, so underrun is set. The captured sample stays staged for the next tick.
- Underrun flags:
  - clr_underrun clears all flags.
  - If clr_underrun and a new underrun occur in the same cycle, the set wins.
- PWM:
  - A shared counter `pcnt` (SAMPLE_W bits) is free-running and wraps from 2^SAMPLE_W-1 to 0.
  - Each channel's duty[i] loads active[i] on the cycle where pcnt is at its maximum.
  - pwm[i] is registered: pwm[i] <= (pcnt < duty[i]).
  - duty=0 gives pwm constantly low. duty=max gives high for max of 2^SAMPLE_W cycles.

## Timing
- Reset values:
  - Internal state: cnt, pcnt, stage, stage_full, active, duty and underrun are all 0.
  - Outputs: pwm=0, mix_pwm=0, s_rdy all 1, tick=(0>=div), which is 1 only when div=0.
- First tick occurs in the cycle where cnt==div, i.e. on the (div+1)th edge after reset release.
- Path from an accepted sample to the pin:
  - A sample accepted at edge E moves to active at the first tick edge T > E.
  - It reaches duty at the first pcnt-maximum edge after T.
  - It affects pwm one edge after that.
- Reset asserted mid-operation clears everything immediately, including staged samples and sticky flags.
- s_rdy is combinational from stage_full; no combinational path from s_vld to s_rdy.

## Configuration
- BYTEBEAT_PWM_MIX_EN defined:
  - mix = (sum of all active[i]) >> log2(CHANNELS). The sum is SAMPLE_W+log2(CHANNELS) bits wide and is registered one cycle.
  - mix feeds a mix_duty register loaded at the pcnt maximum, with the same compare as a channel. mix_pwm is registered.
- BYTEBEAT_PWM_MIX_EN not defined: mix_pwm is tied to 0 and no adder or mix registers are generated.

## Structure
- Package `bytebeat_pkg` holds:
  - the default SAMPLE_W, DIV_W and CHANNELS constants;
  - a typedef for the sample type;
  - a localparam for the log2(CHANNELS) shift.
- Sub-module `pwm_duty_channel` holds the duty shadow register, the load-on-wrap logic and the registered compare.
  - It takes pcnt and a wrap strobe from the parent.
  - It is instantiated CHANNELS times, plus once more for the mix when enabled.
- Top level holds the sample counter, the shared pcnt, the staging/active/underrun arrays and the mix adder.

## Test plan
Defaults unless stated: CHANNELS=4, SAMPLE_W=8, div=511.
- Reset then idle: after 512 cycles, tick pulses once at cycle 511. underrun=4'b1111, pwm stays 0, s_rdy=4'b1111.
- Handshake: s_vld=1 on ch0 with 0x80 at cycle 10. Required:
  - s_rdy[0] falls at cycle 11;
  - a second sample 0x40 is held until the tick;
  - after the tick, active0=0x80 and 0x40 is staged;
  - pwm0 settles to 128 high of every 256 cycles after the next wrap.
- Duty extremes: ch1 fed 0x00 and ch2 fed 0xFF every tick. Required: pwm1 is never high; pwm2 is low exactly 1 cycle per 256.
- Simultaneous capture and tick: present ch3 data 0x11 exactly on the tick cycle. Required: underrun[3] set, active3 unchanged, 0x11 loaded on the following tick. Then clr_underrun clears the flag.
- div change: div=511 with cnt=300, write div=100. Required: tick on the next cycle, then period 101. With div=0, tick is constant high.
- BYTEBEAT_PWM_MIX_EN with channels 0x10, 0x20, 0x30, 0x40: mix = 0xA0>>2 = 0x28, so mix_pwm is high 40 of every 256 cycles. With the macro undefined, mix_pwm stays 0.
